// File: rtl/seg7_scan_mux.sv
// Four-digit 7-segment scan multiplexer. The displayed value is double-buffered and
// changes only at frame boundaries. A blanking gap separates digits, and leading zeros can be blanked.
module seg7_scan_mux #(
  parameter int SCAN_DIV     = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        lz_blank_en,
  output logic [6:0]  seg_out,
  output logic [3:0]  dig_sel,
  output logic        frame_done
);

  localparam int MAX_PHASE = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW        = $clog2(MAX_PHASE + 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_e;

  phase_e        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pending_q, pending_d;
  logic [15:0]   active_q, active_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_end;

  function automatic logic [6:0] enc(input logic [3:0] nib);
    case (nib)
      4'h0: enc = 7'h3F;
      4'h1: enc = 7'h06;
      4'h2: enc = 7'h5B;
      4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66;
      4'h5: enc = 7'h6D;
      4'h6: enc = 7'h7D;
      4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F;
      4'h9: enc = 7'h6F;
      4'hA: enc = 7'h77;
      4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39;
      4'hD: enc = 7'h5E;
      4'hE: enc = 7'h79;
      default: enc = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q      <= PH_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      seg_q        <= '0;
      dig_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  // A load coinciding with the frame boundary goes straight to active via pending_d.
  always_comb begin
    pending_d = load ? value_in : pending_q;
    active_d  = active_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    if (!enable) begin
      phase_d = PH_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (phase_q)
        PH_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            phase_d = PH_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == SCAN_LAST) begin
            phase_d = PH_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              frame_end = 1'b1;
              active_d  = pending_d;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs are computed from next state so they update on the edge that changes the phase.
  always_comb begin
    logic [3:0] nib;
    logic       lz_hit;
    seg_d        = '0;
    dig_d        = '0;
    frame_done_d = frame_end;
    nib          = '0;
    lz_hit       = 1'b0;
    case (idx_d)
      2'd0: nib = active_d[3:0];
      2'd1: nib = active_d[7:4];
      2'd2: nib = active_d[11:8];
      default: nib = active_d[15:12];
    endcase
    case (idx_d)
      2'd0: lz_hit = 1'b0;
      2'd1: lz_hit = (active_d[15:4] == '0);
      2'd2: lz_hit = (active_d[15:8] == '0);
      default: lz_hit = (active_d[15:12] == '0);
    endcase
    if (phase_d == PH_DRIVE) begin
      dig_d = 4'd1 << idx_d;
      seg_d = (lz_blank_en && lz_hit) ? 7'h00 : enc(nib);
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux. Two instances (4/2 and 1/1 timing) are checked
// every cycle against a frame-position model of the scan.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic        lz_blank_en = 1'b0;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic        fd_a, fd_b;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int PB [2] = '{2, 1};
  localparam int PS [2] = '{4, 1};
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          pos  [2];
  logic [15:0] act  [2];
  logic [15:0] pend [2];
  logic [6:0]  e_seg [2];
  logic [3:0]  e_dig [2];
  logic        e_fd  [2];
  logic        cur_lz = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value_in(value_in), .load(load),
    .lz_blank_en(lz_blank_en), .seg_out(seg_a), .dig_sel(dig_a), .frame_done(fd_a));

  seg7_scan_mux #(.SCAN_DIV(1), .BLANK_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value_in(value_in), .load(load),
    .lz_blank_en(lz_blank_en), .seg_out(seg_b), .dig_sel(dig_b), .frame_done(fd_b));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // pos = cycle index within the frame being displayed after this edge.
  task automatic model_step(input int k);
    int   period;
    int   slot;
    int   w;
    logic bnd;
    period = 4 * (PB[k] + PS[k]);
    if (!rst_n) begin
      pend[k] = '0; act[k] = '0; pos[k] = 0;
      e_seg[k] = '0; e_dig[k] = '0; e_fd[k] = 1'b0;
      return;
    end
    bnd = enable && (pos[k] == period - 1);
    if (bnd) act[k] = load ? value_in : pend[k];
    if (load) pend[k] = value_in;
    if (!enable) begin
      pos[k] = 0;
      e_seg[k] = '0; e_dig[k] = '0; e_fd[k] = 1'b0;
      return;
    end
    pos[k] = (pos[k] + 1) % period;
    slot = pos[k] / (PB[k] + PS[k]);
    w    = pos[k] % (PB[k] + PS[k]);
    e_fd[k] = bnd;
    if (w < PB[k]) begin
      e_seg[k] = '0; e_dig[k] = '0;
    end else begin
      e_dig[k] = 4'(1 << slot);
      if (lz_blank_en && slot > 0 && (act[k] >> (4 * slot)) == 16'd0)
        e_seg[k] = '0;
      else
        e_seg[k] = SEG_TAB[(act[k] >> (4 * slot)) & 16'hF];
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic l,
                       input logic [15:0] v, input logic z);
    rst_n = r; enable = e; load = l; value_in = v; lz_blank_en = z;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("a_seg", {9'd0, seg_a}, {9'd0, e_seg[0]});
    chk("a_dig", {12'd0, dig_a}, {12'd0, e_dig[0]});
    chk("a_fd",  {15'd0, fd_a},  {15'd0, e_fd[0]});
    chk("b_seg", {9'd0, seg_b}, {9'd0, e_seg[1]});
    chk("b_dig", {12'd0, dig_b}, {12'd0, e_dig[1]});
    chk("b_fd",  {15'd0, fd_b},  {15'd0, e_fd[1]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0, cur_lz);
  endtask

  // Advance until instance A sits at frame position tgt; a timeout counts as a failure.
  task automatic sync_to(input int tgt);
    int i;
    for (i = 0; i < 100 && pos[0] != tgt; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0, cur_lz);
    chk("sync_timeout", 16'(pos[0]), 16'(tgt));
  endtask

  initial begin
    logic [15:0] mask;
    logic        r, e, l;
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; act[k] = '0; pend[k] = '0;
    end

    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(60);

    sync_to(10);
    cycle(1'b1, 1'b1, 1'b1, 16'h1A2F, cur_lz);
    idle(50);

    sync_to(23);
    cycle(1'b1, 1'b1, 1'b1, 16'h0008, cur_lz);
    idle(30);

    cur_lz = 1'b1;
    sync_to(5);
    cycle(1'b1, 1'b1, 1'b1, 16'h0040, cur_lz);
    idle(50);
    cycle(1'b1, 1'b1, 1'b1, 16'h0000, cur_lz);
    idle(50);
    cur_lz = 1'b0;

    sync_to(15);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, cur_lz);
    cycle(1'b1, 1'b0, 1'b1, 16'h5555, cur_lz);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, cur_lz);
    idle(60);
    sync_to(15);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, cur_lz);
    idle(30);

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 4))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        3: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      if ($urandom_range(0, 29) == 0) cur_lz = ~cur_lz;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 49) != 0);
      l = ($urandom_range(0, 7) == 0);
      cycle(r, e, l, 16'($urandom) & mask, cur_lz);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream display stage for the hex counter/seg7 path. Takes a 16-bit value (four hex digits) and drives a 4-digit common-segment 7-segment display by time-multiplexing.
- Double-buffers the value so updates land only at frame boundaries, which prevents tearing.
- Inserts a blanking gap between digits to suppress ghosting.
- Optionally blanks leading zeros.

Parameters:
- SCAN_DIV, 2500: clk cycles each digit is driven (DRIVE phase length); legal range >= 1.
- BLANK_CYCLES, 16: clk cycles of all-off gap before each digit (BLANK phase length); legal range >= 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  scan enable; 0 turns the display off.
- value_in  input  16  digit3=[15:12], digit2=[11:8], digit1=[7:4], digit0=[3:0].
- load  input  1  one-cycle strobe; captures value_in into the pending register.
- lz_blank_en  input  1  1 = blank leading zero digits.
- seg_out  output  7  segments, active-high; bit0=a through bit6=g.
- dig_sel  output  4  digit enables, one-hot or zero, active-high; bit n = digit n.
- frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame.

Behaviour:
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.
- Internal state:
  - pending[15:0], active[15:0].
  - idx[1:0].
  - phase in {BLANK, DRIVE}.
  - phase counter cnt, width $clog2(max(SCAN_DIV, BLANK_CYCLES)+1).
- Reset (rst_n=0 at posedge):
  - pending=0, active=0, idx=0, phase=BLANK, cnt=0.
  - seg_out=0, dig_sel=0, frame_done=0.
  - Reset mid-frame aborts the scan immediately.
- Load:
  - load=1 sets pending <= value_in the same edge, in any phase and regardless of enable.
  - The last load wins.
- Scan FSM (enable=1):
  - BLANK: dig_sel=0, seg_out=0. After BLANK_CYCLES cycles, go to DRIVE, cnt=0.
  - DRIVE: dig_sel = one-hot(idx), seg_out = enc(active nibble idx) or 0 if lz-blanked. After SCAN_DIV cycles, go to BLANK, cnt=0, idx <= idx+1 (3 wraps to 0).
  - Frame boundary = leaving DRIVE with idx=3:
    - frame_done=1 for exactly that one cycle.
    - active <= (load ? value_in : pending), so a load coincident with the boundary is displayed immediately.
- Frame timing:
  - Frame period = 4*(BLANK_CYCLES+SCAN_DIV).
  - Outputs reflect the new phase on the edge that changes the phase.
- Encoding enc(), hex to seg[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero blanking (lz_blank_en=1):
  - Digit n (n=3,2,1) shows seg_out=0 if active nibbles n..3 are all zero.
  - Digit 0 is never blanked.
  - dig_sel is still asserted during a blanked digit.
  - Evaluated from active only; lz_blank_en is sampled continuously.
- enable=0:
  - Next edge: seg_out=0, dig_sel=0, frame_done=0, idx=0, phase=BLANK, cnt=0.
  - Loads are still accepted into pending, and the pending-to-active transfer is held.
  - When enable rises, the scan restarts at the BLANK of digit 0.
- Arithmetic:
  - cnt compares against PARAM-1 and wraps to 0.
  - idx is 2-bit modulo-4.
  - No other arithmetic.
- Simultaneous events:
  - rst_n overrides enable, which overrides load/scan.
  - load plus frame boundary: see Frame boundary above.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=2 unless noted):
1. Reset/idle: hold rst_n=0 5 cycles -> seg_out=00, dig_sel=0000, frame_done=0. Release with enable=1, no load -> dig_sel pattern per frame is 0000x2, 0001x4, 0000x2, 0010x4, 0000x2, 0100x4, 0000x2, 1000x4, repeating every 24 cycles. seg_out=3F whenever dig_sel!=0. frame_done pulses once per 24 cycles, coincident with the last dig_sel=1000 to 0000 edge.
2. Double buffering: load value 0x1A2F mid-frame -> current frame unchanged (all 3F). Next frame shows digit0=71, digit1=5B, digit2=77, digit3=06.
3. Boundary load: assert load with 0x0008 exactly on the frame_done cycle -> the very next frame shows digit0=7F and digits1-3=3F (lz off).
4. Leading-zero blanking: active=0x0040, lz_blank_en=1 -> digit3 seg 00, digit2 seg 00, digit1 seg 66, digit0 seg 3F. active=0x0000 -> only digit0 lit (3F).
5. Enable/reset mid-operation: deassert enable during DRIVE of digit2 -> outputs 0 next edge. Load 0x5555 while disabled, then re-enable -> BLANK 2 cycles, then digit0 with seg 3F (old active); 0x5555 (6D on all four digits) appears from the following frame. Repeat with rst_n pulsed mid-DRIVE -> all state cleared, active=0.
6. Parameter corner: SCAN_DIV=1, BLANK_CYCLES=1 -> 8-cycle frame, dig_sel alternates 0000/one-hot, frame_done every 8 cycles.
